// File: rtl/turret_servo_sched.sv
// turret_servo_sched: APB motion scheduler for the pan/tilt servos.
// Slews pulse widths toward targets once per frame; shared-counter PWM.
module turret_servo_sched #(
    parameter int TICK_DIV    = 100,
    parameter int FRAME_TICKS = 20000,
    parameter int PW_MIN      = 1000,
    parameter int PW_MAX      = 2000,
    parameter int PW_CENTER   = 1500
) (
    input  logic        PCLK,
    input  logic        PRESET,
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [31:0] PADDR,
    input  logic [31:0] PWDATA,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    output logic        PSLVERR,
    input  logic        SW1,
    input  logic        SW2,
    output logic        pwm_out1,
    output logic        pwm_out2,
    output logic        busy
);

    localparam int PSW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int TW  = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;
    localparam int CW  = (TW > 12) ? TW : 12;

    localparam logic [PSW-1:0] PRE_LAST  = PSW'(TICK_DIV - 1);
    localparam logic [TW-1:0]  TICK_LAST = TW'(FRAME_TICKS - 1);
    localparam logic [11:0]    MIN12     = 12'(PW_MIN);
    localparam logic [11:0]    MAX12     = 12'(PW_MAX);
    localparam logic [11:0]    CTR12     = 12'(PW_CENTER);

    localparam logic [2:0] A_CTRL   = 3'd0;
    localparam logic [2:0] A_TGT1   = 3'd1;
    localparam logic [2:0] A_TGT2   = 3'd2;
    localparam logic [2:0] A_STEP   = 3'd3;
    localparam logic [2:0] A_POS1   = 3'd4;
    localparam logic [2:0] A_POS2   = 3'd5;
    localparam logic [2:0] A_STATUS = 3'd6;

    typedef enum logic {IDLE, RUN} state_t;

    state_t         state_q, state_d;
    logic [PSW-1:0] presc_q;
    logic [TW-1:0]  tick_q;
    logic           en_q, manual_q;
    logic [11:0]    tgt1_q, tgt2_q, pos1_q, pos2_q;
    logic [7:0]     step_q;
    logic           sw1_m, sw1_s, sw2_m, sw2_s;

    logic [2:0]  idx;
    logic        acc, wr, wr_tgt1, en_d, frame_end;
    logic        moving1, moving2;
    logic [7:0]  jstep;
    logic [12:0] up_sum, dn_lim;
    logic [11:0] jog_tgt, tgt1_slew;
    logic [31:0] rd_val;
    logic        unused_bits;

    function automatic logic [11:0] clamp(input logic [11:0] v);
        logic [11:0] r;
        r = v;
        if (v < MIN12) r = MIN12;
        else if (v > MAX12) r = MAX12;
        return r;
    endfunction

    function automatic logic [11:0] slew(input logic [11:0] p,
                                         input logic [11:0] t,
                                         input logic [7:0]  s);
        logic [11:0] d, s12, r;
        s12 = {4'b0, s};
        r   = t;
        if (t > p) begin
            d = t - p;
            if (s != 8'd0 && d > s12) r = p + s12;
        end else begin
            d = p - t;
            if (s != 8'd0 && d > s12) r = p - s12;
        end
        return r;
    endfunction

    assign unused_bits = ^{PADDR[31:5], PADDR[1:0], PWDATA[31:12]};

    assign idx     = PADDR[4:2];
    assign acc     = PSEL & PENABLE;
    assign wr      = acc & PWRITE;
    assign wr_tgt1 = wr && (idx == A_TGT1);
    assign en_d    = (wr && idx == A_CTRL) ? PWDATA[0] : en_q;

    assign frame_end = (state_q == RUN) && (presc_q == PRE_LAST)
                    && (tick_q == TICK_LAST);

    assign moving1 = (pos1_q != tgt1_q);
    assign moving2 = (pos2_q != tgt2_q);
    assign busy    = moving1 | moving2;
    assign PREADY  = 1'b1;

    // State follows EN as it commits, so PWM drops on the write edge.
    always_ff @(posedge PCLK) begin
        if (PRESET) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        pwm_out1 = 1'b0;
        pwm_out2 = 1'b0;
        unique case (state_q)
            IDLE: if (en_d) state_d = RUN;
            RUN: begin
                if (!en_d) state_d = IDLE;
                pwm_out1 = CW'(tick_q) < CW'(pos1_q);
                pwm_out2 = CW'(tick_q) < CW'(pos2_q);
            end
        endcase
    end

    // Counters start on the first RUN cycle, so frame 0 begins at tick 0.
    always_ff @(posedge PCLK) begin
        if (PRESET || state_d == IDLE) begin
            presc_q <= '0;
            tick_q  <= '0;
        end else if (state_q == RUN) begin
            if (presc_q == PRE_LAST) begin
                presc_q <= '0;
                tick_q  <= (tick_q == TICK_LAST) ? '0 : tick_q + 1'b1;
            end else begin
                presc_q <= presc_q + 1'b1;
            end
        end
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            sw1_m <= 1'b0;
            sw1_s <= 1'b0;
            sw2_m <= 1'b0;
            sw2_s <= 1'b0;
        end else begin
            sw1_m <= SW1;
            sw1_s <= sw1_m;
            sw2_m <= SW2;
            sw2_s <= sw2_m;
        end
    end

    always_comb begin
        jstep   = (step_q == 8'd0) ? 8'd1 : step_q;
        up_sum  = {1'b0, tgt1_q} + 13'(jstep);
        dn_lim  = {1'b0, MIN12} + 13'(jstep);
        jog_tgt = tgt1_q;
        if (manual_q && sw1_s && !sw2_s) begin
            jog_tgt = (up_sum > {1'b0, MAX12}) ? MAX12 : up_sum[11:0];
        end else if (manual_q && sw2_s && !sw1_s) begin
            jog_tgt = ({1'b0, tgt1_q} < dn_lim) ? MIN12
                                                : tgt1_q - 12'(jstep);
        end
        tgt1_slew = wr_tgt1 ? tgt1_q : jog_tgt;
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            en_q     <= 1'b0;
            manual_q <= 1'b0;
            step_q   <= 8'd10;
            tgt1_q   <= CTR12;
            tgt2_q   <= CTR12;
            pos1_q   <= CTR12;
            pos2_q   <= CTR12;
        end else begin
            if (frame_end) begin
                pos1_q <= slew(pos1_q, tgt1_slew, step_q);
                pos2_q <= slew(pos2_q, tgt2_q, step_q);
                if (!wr_tgt1) tgt1_q <= jog_tgt;
            end
            if (wr) begin
                case (idx)
                    A_CTRL: begin
                        en_q     <= PWDATA[0];
                        manual_q <= PWDATA[1];
                    end
                    A_TGT1:  tgt1_q <= clamp(PWDATA[11:0]);
                    A_TGT2:  tgt2_q <= clamp(PWDATA[11:0]);
                    A_STEP:  step_q <= PWDATA[7:0];
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        rd_val = 32'd0;
        case (idx)
            A_CTRL:   rd_val = {30'd0, manual_q, en_q};
            A_TGT1:   rd_val = {20'd0, tgt1_q};
            A_TGT2:   rd_val = {20'd0, tgt2_q};
            A_STEP:   rd_val = {24'd0, step_q};
            A_POS1:   rd_val = {20'd0, pos1_q};
            A_POS2:   rd_val = {20'd0, pos2_q};
            A_STATUS: rd_val = {29'd0, en_q, moving2, moving1};
            default:  rd_val = 32'd0;
        endcase
        PRDATA  = (PSEL && !PWRITE) ? rd_val : 32'd0;
        PSLVERR = acc && ((idx == 3'd7)
               || (PWRITE && (idx == A_POS1 || idx == A_POS2
                              || idx == A_STATUS)));
    end

endmodule
